reg_file_writer: RTL and testbench
==================================

Name: reg_file_writer

Overview:
- Write-side counterpart of the register-file read port: accepts (register number, data) write requests over a valid/ready handshake.
- Buffers requests in a small FIFO and commits at most one per cycle into a NUM_REGS x DATA_W register array.
- Out-of-range register numbers are dropped and counted.
- Exposes a registered read port with the same 1-cycle read timing as the existing reader, so downstream `val`-style consumers see committed state.

Parameters:
- NUM_REGS, 10, number of architectural registers.
- DATA_W, 32, register width in bits.
- ADDR_W, 4, register-number width; must satisfy 2**ADDR_W >= NUM_REGS.
- FIFO_DEPTH, 4, write-request buffer entries; power of two, >= 2.

Ports:
- clk  input  1  single clock, all state on posedge.
- rst  input  1  synchronous active-high reset.
- wr_valid  input  1  write request present.
- wr_ready  output  1  writer can accept a request this cycle.
- wr_addr  input  ADDR_W  target register number.
- wr_data  input  DATA_W  write data.
- commit_stall  input  1  blocks FIFO drain this cycle (read-priority arbitration hook).
- rd_addr  input  ADDR_W  read register number.
- rd_data  output  DATA_W  registered read data.
- busy  output  1  FIFO non-empty.
- err_count  output  8  count of dropped out-of-range writes.

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO empty; all array entries = 0; rd_data = 0; err_count = 0.
  - Outputs then read wr_ready = 1 and busy = 0.
  - Reset mid-operation discards all buffered requests; a request presented in the reset cycle is not accepted.
- Accept:
  - Transfer occurs on a posedge with wr_valid && wr_ready.
  - wr_ready = !full, combinational from FIFO count only, never from wr_valid.
  - wr_addr and wr_data are captured together as one entry.
- Commit:
  - On each posedge with FIFO non-empty and commit_stall=0, pop the head entry.
  - If head.addr < NUM_REGS: array[head.addr] <= head.data.
  - Otherwise: no array change, and err_count increments, saturating at 255.
- Latency:
  - Request accepted at edge N is committed at edge N+1 at the earliest, when the FIFO was empty and there is no stall.
  - The committed value is visible on rd_data at edge N+2 if rd_addr targets it during cycle N+1.
  - No same-edge bypass from wr_data to the array.
- Simultaneous push and pop: allowed whenever not full. The count is unchanged, and the head pops while the new entry is appended.
- Full: a push while full is impossible because wr_ready=0. A pop while full frees one slot, and wr_ready rises in the following cycle.
- Empty: no commit and no err_count change; commit_stall is ignored.
- Ordering: commits are strictly FIFO; two writes to the same register leave the later data.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH. Count is tracked with one extra bit to distinguish full from empty.
- Read port:
  - rd_data <= array[rd_addr] on every posedge (not under reset).
  - rd_addr >= NUM_REGS yields 0.
  - A read of a register committed on the same edge returns the old value.
- busy = (count != 0).

Decomposition:
- Shared package reg_file_pkg:
  - Constants NUM_REGS, DATA_W, ADDR_W.
  - Typedef wr_req_t struct {addr[ADDR_W], data[DATA_W]}.
  - These are shared with the existing reader so both ends agree on geometry.
- One sub-module reg_file_wr_fifo:
  - Parameterised by FIFO_DEPTH, payload wr_req_t.
  - Ports: push, push_data, full, pop, pop_data, empty, count.
  - Synchronous active-high reset.
- Top level holds the array, commit logic, error counter and read register.

Test Plan:
- Single write: reset, then push (addr=3, data=0xDEADBEEF) with stall=0, and hold rd_addr=3. Required: rd_data=0 for the first two edges after the push, then 0xDEADBEEF at edge N+2. Also busy=1 for exactly one cycle.
- Fill and drain:
  - Hold commit_stall=1 and push 4 requests (addr 0..3, data 0x10..0x13).
  - Required: wr_ready=0 after the 4th accept, and a 5th valid is held off.
  - Then release stall: registers 0..3 read back 0x10..0x13 in order, and wr_ready=1 one cycle after the first pop.
- Out-of-range:
  - Push addr=10 and addr=15 with data=0xFFFFFFFF.
  - Required: err_count=2, and all 10 registers still read 0.
  - Reading rd_addr=12 gives 0.
  - Then push 300 bad writes: err_count saturates at 255.
- Same-register ordering with streaming push/pop: back-to-back pushes to addr=5 with data 1, 2, 3 and stall=0. Required: the count never exceeds 1 and the final rd_data of reg 5 is 3.
- Reset mid-operation:
  - Stall, push 3 entries, then assert rst for one cycle while wr_valid=1.
  - Required: busy=0, wr_ready=1, and err_count=0 after reset.
  - No buffered entry or reset-cycle request ever reaches the array (all registers read 0).
- Read/commit collision: commit addr=7 data=0xA5 while rd_addr=7 on the same edge. Required: that edge's rd_data is the old value 0, and the next edge gives 0xA5.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Geometry shared by the register-file reader and writer so both ends agree on
// register count, width and the write-request layout.
package reg_file_pkg;

   localparam int unsigned NUM_REGS = 10;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 4;

   // One buffered write request: target register number and its data.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/reg_file_wr_fifo.sv
// Small write-request buffer. Pointers wrap modulo FIFO_DEPTH; the count carries
// one extra bit so full and empty are distinguishable.
module reg_file_wr_fifo
   import reg_file_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter type         payload_t  = wr_req_t
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  payload_t                    push_data,
   output logic                        full,
   input  logic                        pop,
   output payload_t                    pop_data,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   payload_t           mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push_en, pop_en;

   assign full     = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // Pushes are ignored when full and pops when empty, so callers may drive them freely.
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;

   // Next pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_en, pop_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk) begin
      if (!rst && push_en) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/reg_file_writer.sv
// Write side of the register file: buffers (register, data) requests, commits at
// most one per cycle, drops and counts out-of-range targets, and offers a
// registered read port with 1-cycle latency.
module reg_file_writer
   import reg_file_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              commit_stall,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic [7:0]        err_count
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   wr_req_t            push_req;
   wr_req_t            head;
   logic               fifo_full, fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic               commit, in_range;

   logic [DATA_W-1:0]  regs_q [NUM_REGS];
   logic [DATA_W-1:0]  regs_d [NUM_REGS];
   logic [DATA_W-1:0]  rd_data_q, rd_val;
   logic [7:0]         err_q, err_d;

   assign push_req.addr = wr_addr;
   assign push_req.data = wr_data;

   reg_file_wr_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .payload_t  (wr_req_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_valid),
      .push_data (push_req),
      .full      (fifo_full),
      .pop       (commit),
      .pop_data  (head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Ready depends only on occupancy, never on wr_valid.
   assign wr_ready  = !fifo_full;
   assign busy      = (fifo_count != '0);
   assign commit    = !fifo_empty && !commit_stall;
   assign in_range  = (head.addr < ADDR_W'(NUM_REGS));
   assign rd_data   = rd_data_q;
   assign err_count = err_q;

   // Commit the FIFO head into the array, or count it as dropped.
   always_comb begin
      regs_d = regs_q;
      err_d  = err_q;
      if (commit) begin
         if (in_range) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (head.addr == ADDR_W'(i)) regs_d[i] = head.data;
            end
         end else if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
         end
      end
   end

   // Read mux; out-of-range register numbers read as zero.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_addr == ADDR_W'(i)) rd_val = regs_q[i];
      end
   end

   // Array, error counter and read register; a same-edge read sees the old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         err_q     <= '0;
         rd_data_q <= '0;
      end else begin
         regs_q    <= regs_d;
         err_q     <= err_d;
         rd_data_q <= rd_val;
      end
   end

endmodule

// File: tb/tb_reg_file_writer.sv
// Directed bench for reg_file_writer; read expectations go through a scoreboard queue.
module tb_reg_file_writer;
   import reg_file_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              commit_stall;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic [7:0]        err_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   reg_file_writer #(.FIFO_DEPTH(4)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .commit_stall (commit_stall),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .busy         (busy),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and compare rd_data with the oldest queued expectation.
   task automatic rd_step(input string tag);
      logic [31:0] e;
      tick();
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard empty observed=%h", tag, rd_data);
      end else begin
         e = exp_q.pop_front();
         check(tag, rd_data, e);
      end
   endtask

   task automatic rd_chk(input logic [ADDR_W-1:0] a, input logic [31:0] e, input string tag);
      rd_addr = a;
      exp_q.push_back(e);
      rd_step(tag);
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      wr_valid     = 1'b0;
      commit_stall = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      wr_valid     = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      commit_stall = 1'b0;
      rd_addr      = '0;
      tick();
      tick();
      check("rst_ready", 32'(wr_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err_count), 32'd0);
      check("rst_rd", rd_data, 32'd0);
      rst = 1'b0;

      // Single write: visible on rd_data two edges after the accept.
      wr_valid = 1'b1;
      wr_addr  = 4'd3;
      wr_data  = 32'hDEADBEEF;
      rd_addr  = 4'd3;
      exp_q.push_back(32'd0);
      rd_step("sw_edge_n");
      check("sw_busy_hi", 32'(busy), 32'd1);
      wr_valid = 1'b0;
      exp_q.push_back(32'd0);
      rd_step("sw_edge_n1");
      check("sw_busy_lo", 32'(busy), 32'd0);
      exp_q.push_back(32'hDEADBEEF);
      rd_step("sw_edge_n2");

      // Fill under stall, then drain.
      do_reset();
      commit_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1;
         wr_addr  = ADDR_W'(i);
         wr_data  = 32'h10 + 32'(i);
         check("fill_ready", 32'(wr_ready), 32'd1);
         tick();
      end
      check("full_ready", 32'(wr_ready), 32'd0);
      wr_addr = 4'd9;
      wr_data = 32'h99;
      tick();
      check("held_off_ready", 32'(wr_ready), 32'd0);
      wr_valid     = 1'b0;
      commit_stall = 1'b0;
      tick();
      check("ready_after_pop", 32'(wr_ready), 32'd1);
      tick();
      tick();
      tick();
      check("drain_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) rd_chk(ADDR_W'(i), 32'h10 + 32'(i), "drain_reg");
      rd_chk(4'd9, 32'd0, "held_off_reg9");

      // Out-of-range writes are dropped and counted.
      do_reset();
      wr_valid = 1'b1;
      wr_data  = 32'hFFFFFFFF;
      wr_addr  = 4'd10;
      tick();
      wr_addr = 4'd15;
      tick();
      wr_valid = 1'b0;
      tick();
      tick();
      check("oor_err2", 32'(err_count), 32'd2);
      for (int i = 0; i < 10; i++) rd_chk(ADDR_W'(i), 32'd0, "oor_reg_zero");
      rd_chk(4'd12, 32'd0, "oor_rd12");
      wr_valid = 1'b1;
      wr_addr  = 4'd11;
      for (int i = 0; i < 300; i++) tick();
      wr_valid = 1'b0;
      tick();
      tick();
      check("oor_saturate", 32'(err_count), 32'd255);
      check("oor_busy", 32'(busy), 32'd0);

      // Streaming pushes to one register.
      do_reset();
      wr_valid = 1'b1;
      wr_addr  = 4'd5;
      for (int i = 1; i <= 3; i++) begin
         wr_data = 32'(i);
         tick();
         check("stream_count_le1", 32'(u_dut.u_fifo.count <= 3'd1), 32'd1);
         check("stream_ready", 32'(wr_ready), 32'd1);
      end
      wr_valid = 1'b0;
      tick();
      check("stream_busy", 32'(busy), 32'd0);
      rd_chk(4'd5, 32'd3, "stream_reg5");

      // Reset mid-operation with a request in the reset cycle.
      commit_stall = 1'b1;
      wr_valid     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_addr = ADDR_W'(i + 1);
         wr_data = 32'h55 + 32'(i);
         tick();
      end
      rst     = 1'b1;
      wr_addr = 4'd6;
      wr_data = 32'h66;
      tick();
      rst          = 1'b0;
      wr_valid     = 1'b0;
      commit_stall = 1'b0;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ready", 32'(wr_ready), 32'd1);
      check("mid_rst_err", 32'(err_count), 32'd0);
      tick();
      tick();
      for (int i = 0; i < 10; i++) rd_chk(ADDR_W'(i), 32'd0, "mid_rst_reg_zero");

      // Read/commit collision on the same edge returns the old value.
      wr_valid = 1'b1;
      wr_addr  = 4'd7;
      wr_data  = 32'hA5;
      rd_addr  = 4'd0;
      tick();
      wr_valid = 1'b0;
      rd_chk(4'd7, 32'd0, "collide_old");
      exp_q.push_back(32'hA5);
      rd_step("collide_new");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "time limit");
   end

endmodule
